// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - seven-segment pattern constants and digit-to-pattern helper
//
// Contents:
//   SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK : 7-bit active-low patterns {g,f,e,d,c,b,a}
//   blink_phase_t                         : blink half-period state
//   seg_pattern(value, hex_mode)          : 4-bit value -> active-low pattern

package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_t;

  // Values above 9 fall back to "0" when hex display is off, matching the
  // behaviour of the original single-digit decoder.
  function automatic logic [6:0] seg_pattern(input logic [3:0] value,
                                             input logic       hex_mode);
    logic [6:0] p;
    case (value)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: begin
        if (!hex_mode) begin
          p = SEG_0;
        end else begin
          case (value)
            4'hA:    p = SEG_A;
            4'hB:    p = SEG_B;
            4'hC:    p = SEG_C;
            4'hD:    p = SEG_D;
            4'hE:    p = SEG_E;
            default: p = SEG_F;
          endcase
        end
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - single-digit 4-bit value to seven-segment decoder
//
// Ports:
//   value    in  4  digit value 0..15
//   hex_mode in  1  1: 10..15 as A,b,C,d,E,F; 0: 10..15 as "0"
//   seg      out 7  active-low pattern {g,f,e,d,c,b,a}

module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  assign seg = seg_pattern(value, hex_mode);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with guard, dp, blink and zero blanking
//
// Ports:
//   clk        in  1             system clock
//   rst_n      in  1             asynchronous active-low reset
//   digits     in  4*NUM_DIGITS  digit i on [4i+3:4i], digit 0 rightmost
//   pointer    in  clog2(N)      cursor: decimal point and blink target
//   display_en in  1             0: all anodes off, counters keep running
//   blink_en   in  1             1: pointed digit blanks in blink-off phase
//   lz_blank   in  1             1: leading-zero blanking
//   anode      out NUM_DIGITS    registered one-hot digit enable (per polarity)
//   cathode    out 8             registered {dp,g,f,e,d,c,b,a} (per polarity)
//   scan_idx   out clog2(N)      digit slot currently being scanned

module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD_CYCLES   = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [$clog2(NUM_DIGITS)-1:0] pointer,
  input  logic                          display_en,
  input  logic                          blink_en,
  input  logic                          lz_blank,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [7:0]                    cathode,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx
);

  localparam int PTR_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [FRM_W-1:0] LAST_FRM  = FRM_W'(BLINK_FRAMES - 1);

  // "Off" levels for each polarity, also used as reset values.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            CAT_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [CNT_W-1:0]      cnt;
  logic [FRM_W-1:0]      frame_cnt;
  blink_phase_t          phase;

  logic [3:0]            cur_val;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  ptr_hit;
  logic                  blink_blank;
  logic                  lz_blanked;
  logic                  blanked;
  logic                  guard_done;
  logic                  an_on;
  logic                  dp_lit;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_lo;
  logic [7:0]            cat_lo;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [7:0]            cat_next;
  logic [NUM_DIGITS-1:0] an_next;

  // Select the scanned digit and check whether it and every more
  // significant digit are zero (the leading-zero condition).
  always_comb begin
    cur_val    = 4'd0;
    upper_zero = 1'b1;
    onehot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (PTR_W'(i) == scan_idx) begin
        cur_val   = digits[4*i +: 4];
        onehot[i] = 1'b1;
      end
      if ((PTR_W'(i) >= scan_idx) && (digits[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  seg_decoder u_decoder (
    .value    (cur_val),
    .hex_mode (HEX_MODE != 0),
    .seg      (dec_seg)
  );

  // scan_idx never reaches NUM_DIGITS, so an out-of-range pointer simply
  // never matches: no dp and no blink target.
  assign ptr_hit     = (pointer == scan_idx);
  assign blink_blank = blink_en && (phase == BLINK_OFF) && ptr_hit;
  // The pointed digit is exempt, so a blanked digit never carries the dp.
  assign lz_blanked  = lz_blank && (scan_idx != '0) && !ptr_hit && upper_zero;
  assign blanked     = blink_blank || lz_blanked;
  assign guard_done  = (GUARD_CYCLES == 0) || (cnt >= GUARD_END);
  assign an_on       = display_en && guard_done && !blanked;
  assign dp_lit      = ptr_hit && !blink_blank;

  assign seg_lo   = blanked ? SEG_BLANK : dec_seg;
  assign cat_lo   = {~dp_lit, seg_lo};
  assign cat_next = (SEG_ACTIVE_LOW != 0) ? cat_lo : ~cat_lo;
  assign an_hi    = an_on ? onehot : '0;
  assign an_next  = (AN_ACTIVE_LOW != 0) ? ~an_hi : an_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      frame_cnt <= '0;
      phase     <= BLINK_ON;
      scan_idx  <= '0;
      anode     <= AN_OFF;
      cathode   <= CAT_OFF;
    end else begin
      anode   <= an_next;
      cathode <= cat_next;
      if (cnt == LAST_CNT) begin
        cnt <= '0;
        if (scan_idx == LAST_IDX) begin
          // End of a full scan frame drives the blink timebase.
          scan_idx <= '0;
          if (frame_cnt == LAST_FRM) begin
            frame_cnt <= '0;
            phase     <= (phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver (4 digits, div 4, guard 1, blink 2)

module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h1234;
  logic [1:0]  pointer = 2'd0;
  logic        display_en = 1'b1;
  logic        blink_en = 1'b0;
  logic        lz_blank = 1'b0;

  logic [3:0]  an0, an1;
  logic [7:0]  cat0, cat1;
  logic [1:0]  idx0, idx1;

  seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1), .BLINK_FRAMES(2),
    .HEX_MODE(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .pointer(pointer),
    .display_en(display_en), .blink_en(blink_en), .lz_blank(lz_blank),
    .anode(an0), .cathode(cat0), .scan_idx(idx0)
  );

  seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1), .BLINK_FRAMES(2),
    .HEX_MODE(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_hex (
    .clk(clk), .rst_n(rst_n), .digits(digits), .pointer(pointer),
    .display_en(display_en), .blink_en(blink_en), .lz_blank(lz_blank),
    .anode(an1), .cathode(cat1), .scan_idx(idx1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         tgt;
    int         tag;
    int         sel;
    int         mask;
    logic [3:0] an;
    logic [7:0] cat;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   base;

  localparam logic [3:0] SLOT_AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [7:0] T1_CAT  [4] = '{8'b0_0011001, 8'b1_0110000, 8'b1_0100100, 8'b1_1111001};
  localparam logic [3:0] T2_AN   [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
  localparam logic [7:0] T2_CAT  [4] = '{8'b0_1000000, 8'b1_0010010, 8'hFF, 8'hFF};

  // Expected response for the negedge following posedge number tgt.
  task automatic push(input int tgt, input int tag, input int sel, input int mask,
                      input logic [3:0] an, input logic [7:0] cat, input logic [1:0] idx);
    exp_t e;
    int   p;
    e.tgt = tgt; e.tag = tag; e.sel = sel; e.mask = mask;
    e.an = an; e.cat = cat; e.idx = idx;
    p = sb.size();
    while (p > 0 && sb[p-1].tgt > tgt) p--;
    sb.insert(p, e);
  endtask

  // One 4-cycle slot: guard cycle first, scan_idx advances on the last.
  task automatic expect_slot(input int t0, input int tag, input int sel, input int slot,
                             input logic [3:0] an, input logic [7:0] cat);
    for (int j = 0; j < 4; j++) begin
      push(t0 + j, tag, sel, 7, (j == 0) ? 4'hF : an, cat,
           (j == 3) ? 2'((slot + 1) % 4) : 2'(slot));
    end
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic assert_rst(input int tag);
    rst_n = 1'b0;
    push(cyc, tag, 0, 7, 4'hF, 8'hFF, 2'd0);
    push(cyc, tag, 1, 7, 4'hF, 8'hFF, 2'd0);
  endtask

  task automatic finish_rst(output int b);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    b = cyc;
  endtask

  task automatic do_reset(input int tag, output int b);
    @(posedge clk);
    #1;
    assert_rst(tag);
    finish_rst(b);
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [3:0] a;
    logic [7:0] c;
    logic [1:0] x;
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      e = sb.pop_front();
      a = (e.sel != 0) ? an1 : an0;
      c = (e.sel != 0) ? cat1 : cat0;
      x = (e.sel != 0) ? idx1 : idx0;
      if (e.tgt < cyc) begin
        total++; bad++;
        $display("FAIL t%0d stale expectation tgt=%0d now=%0d", e.tag, e.tgt, cyc);
      end else begin
        if (e.mask[0]) begin
          total++;
          if (a !== e.an) begin
            bad++;
            $display("FAIL t%0d anode cyc=%0d sel=%0d got=%b want=%b", e.tag, cyc, e.sel, a, e.an);
          end
        end
        if (e.mask[1]) begin
          total++;
          if (c !== e.cat) begin
            bad++;
            $display("FAIL t%0d cathode cyc=%0d sel=%0d got=%b want=%b", e.tag, cyc, e.sel, c, e.cat);
          end
        end
        if (e.mask[2]) begin
          total++;
          if (x !== e.idx) begin
            bad++;
            $display("FAIL t%0d scan_idx cyc=%0d sel=%0d got=%0d want=%0d", e.tag, cyc, e.sel, x, e.idx);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: plain scan of 1234 with dp on digit 0
    do_reset(1, base);
    for (int s = 0; s < 4; s++) expect_slot(base + 4*s + 1, 10 + s, 0, s, SLOT_AN[s], T1_CAT[s]);
    tick_to(base + 17);

    // 2: leading-zero blanking of 0050
    digits = 16'h0050; lz_blank = 1'b1; pointer = 2'd0;
    do_reset(2, base);
    for (int s = 0; s < 4; s++) expect_slot(base + 4*s + 1, 20 + s, 0, s, T2_AN[s], T2_CAT[s]);
    tick_to(base + 17);

    // 3: blink on digit 2; two frames lit, two frames dark
    digits = 16'h1234; lz_blank = 1'b0; pointer = 2'd2; blink_en = 1'b1;
    do_reset(3, base);
    expect_slot(base + 9,  30, 0, 2, 4'b1011, 8'b0_0100100);
    expect_slot(base + 25, 31, 0, 2, 4'b1011, 8'b0_0100100);
    expect_slot(base + 33, 32, 0, 0, 4'b1110, 8'b1_0011001);
    expect_slot(base + 41, 33, 0, 2, 4'hF, 8'hFF);
    expect_slot(base + 57, 34, 0, 2, 4'hF, 8'hFF);
    expect_slot(base + 73, 35, 0, 2, 4'b1011, 8'b0_0100100);
    push(base + 105, 36, 0, 7, 4'hF, 8'hFF, 2'd2);
    tick_to(base + 105);
    blink_en = 1'b0;
    push(base + 106, 37, 0, 7, 4'b1011, 8'b0_0100100, 2'd2);
    push(base + 107, 37, 0, 7, 4'b1011, 8'b0_0100100, 2'd2);
    tick_to(base + 108);

    // 4: hex values, legacy vs hex decoding
    digits = 16'h00AF; pointer = 2'd0;
    do_reset(4, base);
    expect_slot(base + 1, 40, 0, 0, 4'b1110, 8'b0_1000000);
    expect_slot(base + 5, 41, 0, 1, 4'b1101, 8'b1_1000000);
    expect_slot(base + 1, 42, 1, 0, 4'b1110, 8'b0_0001110);
    expect_slot(base + 5, 43, 1, 1, 4'b1101, 8'b1_0001000);
    tick_to(base + 9);

    // 5: display disabled for 10 cycles mid-slot
    digits = 16'h1234;
    do_reset(5, base);
    tick_to(base + 3);
    display_en = 1'b0;
    for (int k = 4; k <= 13; k++) push(base + k, 50, 0, 5, 4'hF, 8'h00, 2'((k / 4) % 4));
    tick_to(base + 13);
    display_en = 1'b1;
    push(base + 14, 51, 0, 7, 4'b0111, 8'b1_1111001, 2'd3);
    push(base + 15, 51, 0, 7, 4'b0111, 8'b1_1111001, 2'd3);
    tick_to(base + 16);

    // 6: asynchronous reset mid-slot, then restart from digit 0
    do_reset(6, base);
    push(base + 6, 60, 0, 7, 4'b1101, 8'b1_0110000, 2'd1);
    tick_to(base + 7);
    assert_rst(61);
    finish_rst(base);
    expect_slot(base + 1, 62, 0, 0, 4'b1110, 8'b0_0011001);
    tick_to(base + 5);

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain pending=%0d", sb.size());
      total += sb.size();
      bad += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
